// File: rtl/rv_wb_pkg.sv
// Shared types and load-extension helper for the register writeback unit.
package rv_wb_pkg;

  localparam int unsigned WB_XLEN = 32;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_funct3_e;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  // Half loads use lsb[1] only; unknown encodings pass the word through.
  function automatic logic [WB_XLEN-1:0] load_extend(input logic [2:0]         funct3,
                                                     input logic [1:0]         lsb,
                                                     input logic [WB_XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lsb)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lsb[1] ? word[31:16] : word[15:0];
    case (funct3)
      LD_LB:   load_extend = {{24{b[7]}}, b};
      LD_LH:   load_extend = {{16{h[15]}}, h};
      LD_LBU:  load_extend = {24'd0, b};
      LD_LHU:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/wb_alu_fifo.sv
// In-order circular FIFO of pending ALU writebacks, with per-slot rd exposure
// so the hazard check can see every queued destination.
module wb_alu_fifo
  import rv_wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock_i,
  input  logic                  resetb_i,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_rd
);

  wb_entry_t         mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= next_ptr(rd_ptr);
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    entry_rd = '0;
    for (int unsigned i = 0; i < DEPTH; i++) entry_rd[i] = mem[i].rd;
  end

  assign entry_valid = vld;
  assign head        = mem[rd_ptr];
  assign count       = cnt;
  assign full        = (cnt == CW'(DEPTH));
  assign empty       = (cnt == '0);

endmodule

// File: rtl/reg_writeback_unit.sv
// Merges load returns and ALU results onto the single register-file write
// port; loads win, displaced ALU results queue in order.
module reg_writeback_unit
  import rv_wb_pkg::*;
#(
  parameter int unsigned ALU_DEPTH = 2,
  parameter int unsigned XLEN      = 32
) (
  input  logic                           clock_i,
  input  logic                           resetb_i,
  input  logic                           alu_valid_i,
  output logic                           alu_ready_o,
  input  logic [4:0]                     alu_rd_i,
  input  logic [XLEN-1:0]                alu_data_i,
  input  logic                           ld_valid_i,
  input  logic [4:0]                     ld_rd_i,
  input  logic [2:0]                     ld_funct3_i,
  input  logic [1:0]                     ld_addr_lsb_i,
  input  logic [XLEN-1:0]                ld_data_i,
  input  logic [4:0]                     rs1_i,
  input  logic [4:0]                     rs2_i,
  output logic                           raw_hazard_o,
  output logic                           write_ena_o,
  output logic [4:0]                     W_adress_o,
  output logic [XLEN-1:0]                d_o,
  output logic [$clog2(ALU_DEPTH+1)-1:0] fifo_count_o
);

  wb_entry_t                head;
  logic                     full, empty;
  logic [ALU_DEPTH-1:0]     entry_valid;
  logic [ALU_DEPTH-1:0][4:0] entry_rd;

  logic                     ld_fire, alu_fire;
  logic                     push, pop;
  logic                     sel_valid;
  logic [4:0]               sel_rd;
  logic [XLEN-1:0]          sel_data;

  assign alu_ready_o = !full;
  // rd==0 beats are accepted but dropped, so they never claim the port.
  assign ld_fire     = ld_valid_i && (ld_rd_i != 5'd0);
  assign alu_fire    = alu_valid_i && alu_ready_o && (alu_rd_i != 5'd0);

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    pop       = 1'b0;
    if (ld_fire) begin
      sel_valid = 1'b1;
      sel_rd    = ld_rd_i;
      sel_data  = load_extend(ld_funct3_i, ld_addr_lsb_i, ld_data_i);
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_rd    = head.rd;
      sel_data  = head.data;
      pop       = 1'b1;
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd_i;
      sel_data  = alu_data_i;
    end
    push = alu_fire && (ld_fire || !empty);
  end

  wb_alu_fifo #(.DEPTH(ALU_DEPTH)) u_fifo (
    .clock_i     (clock_i),
    .resetb_i    (resetb_i),
    .push        (push),
    .push_entry  ('{rd: alu_rd_i, data: alu_data_i}),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .count       (fifo_count_o),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      write_ena_o <= 1'b0;
      W_adress_o  <= '0;
      d_o         <= '0;
    end else begin
      write_ena_o <= sel_valid;
      if (sel_valid) begin
        W_adress_o <= sel_rd;
        d_o        <= sel_data;
      end
    end
  end

  function automatic logic pending(input logic [4:0] rs);
    logic hit;
    hit = (write_ena_o && (W_adress_o == rs)) || (sel_valid && (sel_rd == rs));
    for (int unsigned i = 0; i < ALU_DEPTH; i++)
      if (entry_valid[i] && (entry_rd[i] == rs)) hit = 1'b1;
    return (rs != 5'd0) && hit;
  endfunction

  assign raw_hazard_o = pending(rs1_i) || pending(rs2_i);

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Randomized and directed checks of reg_writeback_unit against a queue-based
// reference model of the writeback arbitration rules.
module tb_reg_writeback_unit;

  localparam int unsigned DEPTH = 2;

  logic        clock = 1'b0;
  logic        resetb;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_lsb;
  logic [31:0] ld_data;
  logic [4:0]  rs1, rs2;
  logic        raw_hazard, write_ena;
  logic [4:0]  w_addr;
  logic [31:0] d;
  logic [1:0]  fifo_count;

  always #5 clock = ~clock;

  reg_writeback_unit #(.ALU_DEPTH(DEPTH), .XLEN(32)) dut (
    .clock_i       (clock),
    .resetb_i      (resetb),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_rd_i      (alu_rd),
    .alu_data_i    (alu_data),
    .ld_valid_i    (ld_valid),
    .ld_rd_i       (ld_rd),
    .ld_funct3_i   (ld_funct3),
    .ld_addr_lsb_i (ld_lsb),
    .ld_data_i     (ld_data),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .raw_hazard_o  (raw_hazard),
    .write_ena_o   (write_ena),
    .W_adress_o    (w_addr),
    .d_o           (d),
    .fifo_count_o  (fifo_count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } beat_t;

  int unsigned errors = 0;
  int unsigned checks = 0;

  beat_t       q[$];
  beat_t       wr_log[$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_d;
  logic        last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  by;
    logic [15:0] hw;
    sh = w >> (8 * lsb);
    by = sh[7:0];
    sh = w >> (16 * lsb[1]);
    hw = sh[15:0];
    case (f3)
      3'd0:    return 32'($signed(by));
      3'd1:    return 32'($signed(hw));
      3'd4:    return 32'(by);
      3'd5:    return 32'(hw);
      default: return w;
    endcase
  endfunction

  function automatic logic ref_hit(input logic [4:0] rs, input logic sv, input logic [4:0] srd);
    if (rs == 0) return 1'b0;
    if (exp_we && exp_addr == rs) return 1'b1;
    if (sv && srd == rs) return 1'b1;
    foreach (q[i]) if (q[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  // Called at posedge+1; returns at the following posedge+1 with inputs held.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                      input logic [1:0] lsb, input logic [31:0] ldw,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic        rdy, acc, sv, bypass;
    logic [4:0]  srd;
    logic [31:0] sd;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_lsb = lsb; ld_data = ldw;
    rs1 = r1; rs2 = r2;
    #1;
    rdy = (q.size() < DEPTH);
    check("alu_ready", alu_ready, rdy);
    acc = av && rdy;
    sv = 1'b0; srd = 0; sd = 0; bypass = 1'b0;
    if (lv && lrd != 0) begin
      sv = 1'b1; srd = lrd; sd = ref_load(f3, lsb, ldw);
    end else if (q.size() != 0) begin
      sv = 1'b1; srd = q[0].rd; sd = q[0].data;
    end else if (acc && ard != 0) begin
      sv = 1'b1; srd = ard; sd = ad; bypass = 1'b1;
    end
    check("raw_hazard", raw_hazard, ref_hit(r1, sv, srd) || ref_hit(r2, sv, srd));
    if (!(lv && lrd != 0) && q.size() != 0) void'(q.pop_front());
    if (acc && ard != 0 && !bypass) q.push_back('{rd: ard, data: ad});
    last_acc = acc;
    exp_we = sv;
    if (sv) begin exp_addr = srd; exp_d = sd; end
    @(posedge clock); #1;
    check("write_ena", write_ena, exp_we);
    check("w_addr", w_addr, exp_addr);
    check("d", d, exp_d);
    check("count", fifo_count, q.size());
    if (write_ena) wr_log.push_back('{rd: w_addr, data: d});
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  initial begin
    logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
    logic [1:0]  lsbs[5] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1};
    logic [31:0] exps[5] = '{32'hFFFFFF85, 32'h00000085, 32'hFFFF80F0, 32'h000080F0, 32'h0000007F};
    logic [31:0] got_seq;
    int unsigned n;

    resetb = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0; ld_valid = 0; ld_rd = 0;
    ld_funct3 = 0; ld_lsb = 0; ld_data = 0; rs1 = 0; rs2 = 0;
    exp_we = 0; exp_addr = 0; exp_d = 0; last_acc = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_we", write_ena, 0);
    check("rst_addr", w_addr, 0);
    check("rst_d", d, 0);
    check("rst_count", fifo_count, 0);
    resetb = 1'b1;

    // ALU-only bypass
    step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    check("bypass_d", d, 32'h1234);
    check("bypass_cnt", fifo_count, 0);

    // Load/ALU collision
    step(1, 7, 32'h11, 1, 3, 3'd2, 0, 32'hAABBCCDD, 0, 0);
    check("coll_ld", d, 32'hAABBCCDD);
    check("coll_cnt1", fifo_count, 1);
    idle(0, 0);
    check("coll_alu_addr", w_addr, 7);
    check("coll_alu_d", d, 32'h11);

    // Back-pressure under three loads, then order check
    wr_log.delete();
    step(1, 10, 32'h1, 1, 20, 3'd2, 0, 32'hA0, 0, 0);
    step(1, 10, 32'h2, 1, 21, 3'd2, 0, 32'hA1, 0, 0);
    check("bp_ready_low", alu_ready, 0);
    step(1, 10, 32'h3, 1, 22, 3'd2, 0, 32'hA2, 0, 0);
    n = 0;
    do begin
      step(1, 10, 32'h3, 0, 0, 0, 0, 0, 0, 0);
      n++;
    end while (!last_acc && n < 8);
    check("bp_accept_bound", last_acc, 1);
    repeat (4) idle(0, 0);
    got_seq = 0;
    n = 0;
    foreach (wr_log[i]) if (wr_log[i].rd == 10 && n < 4) begin
      got_seq[8*n +: 8] = wr_log[i].data[7:0];
      n++;
    end
    check("bp_order", got_seq, 32'h00030201);

    // Load extension
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 6, f3s[i], lsbs[i], 32'h80F07F85, 0, 0);
      check($sformatf("ext%0d", i), d, exps[i]);
    end

    // x0 and hazard tracking
    idle(0, 0);
    step(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    check("x0_no_write", write_ena, 0);
    step(1, 9, 32'h99, 1, 4, 3'd2, 0, 32'h44, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    check("haz_writing", raw_hazard, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    check("haz_cleared", raw_hazard, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    check("haz_rs2_zero", raw_hazard, 0);

    // Reset mid-operation with two queued entries
    step(1, 11, 32'hB1, 1, 23, 3'd2, 0, 32'hC1, 0, 0);
    step(1, 12, 32'hB2, 1, 24, 3'd2, 0, 32'hC2, 0, 0);
    check("pre_rst_cnt", fifo_count, 2);
    alu_valid = 0; ld_valid = 0;
    resetb = 1'b0;
    #1;
    check("mid_rst_we", write_ena, 0);
    check("mid_rst_cnt", fifo_count, 0);
    q.delete();
    exp_we = 0; exp_addr = 0; exp_d = 0;
    @(posedge clock); #1;
    resetb = 1'b1;
    wr_log.delete();
    repeat (4) idle(11, 12);
    check("rst_discard", wr_log.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 3'($urandom),
           2'($urandom), $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (3) idle(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Writer-side partner of the register file. It merges two result streams, integer ALU results and load-data returns, into the file's single write port (write enable, 5-bit address, 32-bit data).
- Loads have priority over ALU results. ALU results that lose a cycle are held in a small in-order FIFO.
- Performs RV32I load byte/half extraction and sign/zero extension.
- Exposes a RAW-hazard flag so decode can stall on registers whose write is still pending.

Parameters:
- ALU_DEPTH, 2, ALU result FIFO entries (>=1).
- XLEN, 32, data width.

Ports:
- clock_i  input  1  clock
- resetb_i  input  1  reset, asynchronous, active-low
- alu_valid_i  input  1  ALU result valid
- alu_ready_o  output  1  ALU result accepted when valid&ready
- alu_rd_i  input  5  ALU destination register
- alu_data_i  input  XLEN  ALU result
- ld_valid_i  input  1  load return valid (always accepted, no ready)
- ld_rd_i  input  5  load destination register
- ld_funct3_i  input  3  load type (LB/LH/LW/LBU/LHU)
- ld_addr_lsb_i  input  2  byte offset of load address
- ld_data_i  input  XLEN  raw aligned memory word
- rs1_i  input  5  decode source register 1
- rs2_i  input  5  decode source register 2
- raw_hazard_o  output  1  rs1/rs2 matches a pending write
- write_ena_o  output  1  register file write enable
- W_adress_o  output  5  register file write address
- d_o  output  XLEN  register file write data
- fifo_count_o  output  $clog2(ALU_DEPTH+1)  ALU FIFO occupancy

Behaviour:
- Reset, asynchronous: write_ena_o=0, W_adress_o=0, d_o=0, FIFO empty (count 0, pointers 0). A reset mid-operation discards all queued entries.
- Write-port outputs are registered. A beat selected in cycle N appears on write_ena_o/W_adress_o/d_o in cycle N+1, held one cycle.
- Per-cycle source selection, at most one write per cycle:
  1. ld_valid_i (load wins unconditionally).
  2. Else the FIFO head, if the FIFO is non-empty.
  3. Else an incoming ALU beat (bypass, not enqueued).
  4. Else write_ena_o=0 next cycle; W_adress_o and d_o hold their previous values.
- alu_ready_o = (count < ALU_DEPTH). It is combinational from occupancy only and does not depend on ld_valid_i.
- An accepted ALU beat that is not bypassed is enqueued at the tail. Simultaneous enqueue and dequeue leave count unchanged.
- ALU results are written strictly in acceptance order.
- rd==0 on either channel: the beat is accepted, is never enqueued and never written, and consumes no write slot. A lower-priority source may use that cycle.
- Load extraction, with offset byte b = ld_addr_lsb_i:
  - LB (000): sign-extend byte b.
  - LH (001): sign-extend half (lsb[1]).
  - LW (010): word.
  - LBU (100): zero-extend byte b.
  - LHU (101): zero-extend half (lsb[1]).
  - Any other encoding: word.
  - A half load ignores lsb[0].
- raw_hazard_o is combinational. It is 1 if rs1_i or rs2_i is nonzero and equals any of:
  - a valid FIFO entry's rd,
  - W_adress_o while write_ena_o=1 (the file updates at the end of that cycle),
  - an in-flight selected beat.
- Full FIFO with ld_valid_i every cycle: ALU is stalled (ready=0) indefinitely. Load starvation of ALU is acceptable by contract.
- No WAW ordering between the load and ALU channels is enforced. Upstream guarantees that no two in-flight writes target the same rd across channels.

Decomposition:
- Package rv_wb_pkg holds:
  - load funct3 enum: LB, LH, LW, LBU, LHU.
  - wb_entry_t struct {rd[4:0], data[XLEN-1:0]}.
  - function load_extend(funct3, lsb, word).
- Sub-module wb_alu_fifo: parameterised circular FIFO of wb_entry_t. It provides push/pop/full/empty/count and a per-entry valid+rd vector for the hazard compare.

Test Plan:
- ALU only: alu_valid_i=1, rd=5, data=0x1234 with FIFO empty -> next cycle write_ena_o=1, W_adress_o=5, d_o=0x1234; FIFO count stays 0.
- Collision: same cycle ld (rd=3, LW, 0xAABBCCDD) and ALU (rd=7, 0x11) -> cycle+1 writes x3=0xAABBCCDD, cycle+2 writes x7=0x11; count goes 1 then 0.
- Back-pressure: 3 consecutive loads plus ALU beats 0x1, 0x2, 0x3 with ALU_DEPTH=2 -> alu_ready_o drops after 2 enqueued. After the loads finish, writes occur in order 0x1, 0x2, 0x3.
- Extension with ld_data_i=0x80F0_7F85:
  - LB lsb=0 -> 0xFFFFFF85
  - LBU lsb=0 -> 0x00000085
  - LH lsb=2 -> 0xFFFF80F0
  - LHU lsb=2 -> 0x000080F0
  - LB lsb=1 -> 0x0000007F
- x0 / hazard: ALU rd=0 -> no write_ena_o. ALU rd=9 queued behind a load, with rs1_i=9 -> raw_hazard_o=1 until the cycle after x9 is written. rs2_i=0 -> never flags.
- Reset mid-operation: FIFO holding 2 entries, resetb_i low for one cycle -> write_ena_o=0 and count=0 immediately; queued entries are never written.
